// File: rtl/queue_drain.sv
// Read-side drain engine for a pipeline FIFO: pops into a 2-entry skid buffer,
// streams it out on valid/ready, and can flush the queue to empty.
module queue_drain #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_data,
  input  logic             q_oready,
  input  logic             q_empty,
  output logic             q_re,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy,
  output logic [CNTW-1:0]  pop_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic             flush_prev_q, flush_prev_d;
  logic             flush_done_q, flush_done_d;
  logic [CNTW-1:0]  pop_count_q, pop_count_d;
  logic             hs;

  assign q_re = !rst && ((state_q == ST_FLUSH) ? q_oready
                                               : (q_oready && (cnt_q != 2'd2)));
  assign hs         = (state_q == ST_RUN) && (cnt_q != 2'd0) && out_ready;
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = buf0_q;
  assign flush_done = flush_done_q;
  assign busy       = (state_q == ST_FLUSH) || (cnt_q != 2'd0);
  assign pop_count  = pop_count_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    flush_prev_d = flush;
    flush_done_d = 1'b0;
    pop_count_d  = pop_count_q + {{(CNTW-1){1'b0}}, q_re};
    case (state_q)
      ST_RUN: begin
        // Only a fresh assertion starts a flush, so a level held across
        // completion does not immediately start another one.
        if (flush && !flush_prev_q) begin
          state_d = ST_FLUSH;
          cnt_d   = 2'd0;
        end else if (q_re && hs) begin
          buf0_d = q_data;
        end else if (hs) begin
          buf0_d = buf1_q;
          cnt_d  = cnt_q - 2'd1;
        end else if (q_re) begin
          if (cnt_q == 2'd0) buf0_d = q_data;
          else               buf1_d = q_data;
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        cnt_d = 2'd0;
        if (q_empty && !q_oready) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cnt_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      flush_prev_q <= 1'b0;
      flush_done_q <= 1'b0;
      pop_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      flush_prev_q <= flush_prev_d;
      flush_done_q <= flush_done_d;
      pop_count_q  <= pop_count_d;
    end
  end

endmodule

// File: tb/tb_queue_drain.sv
// Directed bench for queue_drain: behavioural queue on the read port and a
// scoreboard of expected stream data checked at each output handshake.
module tb_queue_drain;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] q_data;
  logic             q_oready, q_empty, q_re;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready, flush, flush_done, busy;
  logic [CNTW-1:0]  pop_count;

  logic [7:0] mem [256];
  logic [7:0] head = 8'd0;
  logic [7:0] tail = 8'd0;
  logic [7:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;

  assign q_data   = mem[head];
  assign q_oready = (head != tail);
  assign q_empty  = (head == tail);

  queue_drain #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .q_data(q_data), .q_oready(q_oready),
    .q_empty(q_empty), .q_re(q_re), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .flush_done(flush_done), .busy(busy), .pop_count(pop_count));

  always #5 clk = ~clk;

  always @(posedge clk) if (q_re) head <= head + 8'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check("stream_data", 32'(out_data), 32'(sb.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input bit exp);
    mem[tail] = v;
    tail = tail + 8'd1;
    if (exp) sb.push_back(v);
  endtask

  task automatic do_reset(input bit keep);
    rst = 1'b1;
    #1;
    check("rst_q_re", 32'(q_re), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    check("rst_pop_count", 32'(pop_count), 0);
    cyc(2);
    if (!keep) begin
      tail = head;
      sb.delete();
    end
    rst = 1'b0;
  endtask

  initial begin
    int pulses, pk;
    bit vseen;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    do_reset(0);

    // streaming with latency 1
    out_ready = 1'b1;
    push(8'd15, 1); push(8'd17, 1); push(8'd20, 1); push(8'd25, 1);
    #1;
    check("t1_q_re", 32'(q_re), 1);
    cyc(1);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_first", 32'(out_data), 15);
    cyc(5);
    check("t1_pop_count", 32'(pop_count), 4);
    check("t1_drained", 32'(sb.size()), 0);
    check("t1_idle", 32'(busy), 0);

    // backpressure
    do_reset(0);
    out_ready = 1'b0;
    push(8'd15, 1); push(8'd17, 1); push(8'd20, 1); push(8'd25, 1);
    cyc(5);
    check("t2_pop_count", 32'(pop_count), 2);
    check("t2_valid", 32'(out_valid), 1);
    check("t2_hold", 32'(out_data), 15);
    check("t2_stall", 32'(q_re), 0);
    out_ready = 1'b1;
    #1;
    check("t2_no_re_yet", 32'(q_re), 0);
    cyc(1);
    check("t2_re_back", 32'(q_re), 1);
    check("t2_next", 32'(out_data), 17);
    cyc(5);
    check("t2_pop_count_end", 32'(pop_count), 4);
    check("t2_drained", 32'(sb.size()), 0);

    // steady state at one entry: pop and handshake on every edge
    do_reset(0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(31 + i), 1);
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      check("t3_valid", 32'(out_valid), 1);
      check("t3_re", 32'(q_re), 1);
      check("t3_data", 32'(out_data), 32'(31 + i));
      cyc(1);
    end
    check("t3_last", 32'(out_data), 35);
    check("t3_last_re", 32'(q_re), 0);
    cyc(2);
    check("t3_drained", 32'(sb.size()), 0);
    check("t3_idle", 32'(busy), 0);

    // flush with full buffer and three queued entries
    do_reset(0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(50 + i), 0);
    cyc(4);
    check("t4_pre_pops", 32'(pop_count), 2);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    check("t4_valid_off", 32'(out_valid), 0);
    check("t4_busy", 32'(busy), 1);
    check("t4_re", 32'(q_re), 1);
    pulses = 0; pk = 0; vseen = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      vseen |= out_valid;
      if (flush_done) begin
        pulses++; pk = k;
        check("t4_busy_drop", 32'(busy), 0);
      end
    end
    check("t4_pulses", 32'(pulses), 1);
    check("t4_pulse_cycle", 32'(pk), 4);
    check("t4_no_valid", 32'(vseen), 0);
    check("t4_pop_count", 32'(pop_count), 5);

    // flush held on an empty queue
    do_reset(0);
    flush = 1'b1;
    pulses = 0; pk = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (flush_done) begin pulses++; pk = k; end
    end
    flush = 1'b0;
    check("t5_pulses", 32'(pulses), 1);
    check("t5_pulse_cycle", 32'(pk), 2);
    check("t5_pop_count", 32'(pop_count), 0);

    // reset in the middle of a stream with a full buffer
    do_reset(0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(40 + i), 0);
    cyc(4);
    check("t6_full", 32'(out_valid), 1);
    check("t6_pre_pops", 32'(pop_count), 2);
    do_reset(1);
    sb.push_back(8'd42); sb.push_back(8'd43); sb.push_back(8'd44);
    out_ready = 1'b1;
    cyc(1);
    check("t6_first", 32'(out_data), 42);
    check("t6_restart", 32'(pop_count), 1);
    cyc(5);
    check("t6_pop_count", 32'(pop_count), 3);
    check("t6_drained", 32'(sb.size()), 0);

    // pop counter wrap with a 4-bit counter
    do_reset(0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'(100 + i), 1);
    cyc(20);
    check("t7_wrap", 32'(pop_count), 1);
    check("t7_drained", 32'(sb.size()), 0);
    check("t7_idle", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
